// File: rtl/pe_mac_sequencer.sv
// Drives one registered signed MAC PE through an L-beat dot product.
// Takes a (length, bias) command and returns the final sum on a valid/ready result port.
module pe_mac_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [ACC_WIDTH-1:0]  cmd_bias,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic [DATA_WIDTH-1:0] pe_a,
  output logic [DATA_WIDTH-1:0] pe_b,
  output logic [ACC_WIDTH-1:0]  pe_c,
  output logic                  pe_valid,
  input  logic [ACC_WIDTH-1:0]  pe_d,
  input  logic                  pe_dvalid,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic                   first_q, first_d;
  logic [ACC_WIDTH-1:0]   bias_q, bias_d;
  logic [ACC_WIDTH-1:0]   res_data_q, res_data_d;
  logic                   res_valid_q, res_valid_d;
  logic                   busy_q, busy_d;

  // Handshake readiness is a pure decode of the state register.
  assign cmd_ready = (state_q == S_IDLE);
  assign op_ready  = (state_q == S_RUN);

  // The PE register holds the running sum, so only the first beat injects the bias.
  assign pe_valid = op_ready & op_valid;
  assign pe_a     = pe_valid ? op_a : DATA_WIDTH'(0);
  assign pe_b     = pe_valid ? op_b : DATA_WIDTH'(0);
  assign pe_c     = pe_valid ? (first_q ? bias_q : pe_d) : ACC_WIDTH'(0);

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      first_q     <= 1'b0;
      bias_q      <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      bias_q      <= bias_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    bias_d      = bias_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          bias_d      = cmd_bias;
          remaining_d = cmd_len;
          first_d     = 1'b1;
          busy_d      = 1'b1;
          // A zero-length command never touches the PE; the bias is the result.
          if (cmd_len == LEN_WIDTH'(0)) begin
            state_d     = S_DONE;
            res_data_d  = cmd_bias;
            res_valid_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (op_valid) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          first_d     = 1'b0;
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        res_data_d  = pe_d;
        res_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The last beat must have landed in the PE by the drain cycle.
  a_drain_pe_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_DRAIN) |-> pe_dvalid);

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Directed bench for pe_mac_sequencer with a behavioural PE and a result scoreboard.
module tb_pe_mac_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] cmd_bias;
  logic          op_valid, op_ready;
  logic [DW-1:0] op_a, op_b;
  logic [DW-1:0] pe_a, pe_b;
  logic [AW-1:0] pe_c;
  logic          pe_valid;
  logic [AW-1:0] pe_d;
  logic          pe_dvalid;
  logic          res_valid, res_ready;
  logic [AW-1:0] res_data;
  logic          busy;

  typedef struct {
    logic [AW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   pe_pulses = 0;
  bit   seen = 0;

  pe_mac_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_bias(cmd_bias),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .pe_a(pe_a), .pe_b(pe_b), .pe_c(pe_c), .pe_valid(pe_valid),
    .pe_d(pe_d), .pe_dvalid(pe_dvalid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural PE: registered signed multiply-accumulate, wraps at AW bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_d      <= '0;
      pe_dvalid <= 1'b0;
    end else begin
      pe_dvalid <= pe_valid;
      if (pe_valid)
        pe_d <= AW'($signed(pe_a) * $signed(pe_b)) + pe_c;
    end
  end

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scores every cycle the DUT presents a result.
  always @(negedge clk) begin
    if (pe_valid) pe_pulses++;
    if (!rst_n) begin
      seen = 0;
    end else if (res_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        if (!seen) check("res_latency", AW'(cyc), AW'(exp_q[0].cyc));
        seen = 1;
        check("res_data", res_data, exp_q[0].data);
        check("cmd_ready_in_done", AW'(cmd_ready), 32'd0);
        check("op_ready_in_done", AW'(op_ready), 32'd0);
        if (res_ready) begin
          void'(exp_q.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic send_cmd(input logic [LW-1:0] len, input logic [AW-1:0] bias,
                          input logic [AW-1:0] exp, input int lat, input bit push);
    int n = 0;
    cmd_len   = len;
    cmd_bias  = bias;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
    if (push) exp_q.push_back('{data: exp, cyc: cyc + lat});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic beat(input int a, input int b);
    op_a     = DW'(a);
    op_b     = DW'(b);
    op_valid = 1'b1;
    check("op_ready_in_run", AW'(op_ready), 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      op_valid = 1'b0;
      #2;
      check("pe_valid_in_gap", AW'(pe_valid), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0) check("result_timeout", AW'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_bias = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_res_valid", AW'(res_valid), 32'd0);
    check("rst_busy", AW'(busy), 32'd0);
    check("rst_cmd_ready", AW'(cmd_ready), 32'd1);
    check("rst_op_ready", AW'(op_ready), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: 10 + 2 + 12 - 30 - 56 = -62, back-to-back beats
    send_cmd(16'd4, 32'd10, -32'sd62, 6, 1'b1);
    beat(1, 2); op_valid = 1'b1; beat(3, 4); op_valid = 1'b1; beat(-5, 6); beat(7, -8);
    check("busy_after_beats", AW'(busy), 32'd1);
    wait_empty();

    // 2: same with a 3-cycle gap after beat 2
    send_cmd(16'd4, 32'd10, -32'sd62, 9, 1'b1);
    beat(1, 2); beat(3, 4); gap(3); beat(-5, 6); beat(7, -8);
    wait_empty();

    // 3: zero-length command returns the bias without touching the PE
    pe_pulses = 0;
    send_cmd(16'd0, -32'sd7, -32'sd7, 1, 1'b1);
    wait_empty();
    check("l0_pe_pulses", AW'(pe_pulses), 32'd0);

    // 4: result back-pressure; 1 + 2*3 = 7 must stay stable while held
    res_ready = 1'b0;
    send_cmd(16'd1, 32'd1, 32'd7, 3, 1'b1);
    beat(2, 3);
    repeat (6) @(posedge clk);
    #1;
    check("held_busy", AW'(busy), 32'd1);
    check("held_res_valid", AW'(res_valid), 32'd1);
    res_ready = 1'b1;
    wait_empty();

    // 5: accumulator wraps
    send_cmd(16'd2, 32'h7FFF_FFFF, 32'h8000_0001, 4, 1'b1);
    beat(1, 1); beat(1, 1);
    wait_empty();
    check("idle_busy", AW'(busy), 32'd0);

    // 6: reset during beat 2 of an 8-beat command discards it
    send_cmd(16'd8, 32'd0, 32'd0, 0, 1'b0);
    beat(4, 4);
    op_a = DW'(5); op_b = DW'(5); op_valid = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("abort_busy", AW'(busy), 32'd0);
    check("abort_res_valid", AW'(res_valid), 32'd0);
    check("abort_cmd_ready", AW'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_abort_res_valid", AW'(res_valid), 32'd0);
    send_cmd(16'd1, 32'd0, 32'd9, 3, 1'b1);
    beat(3, 3);
    wait_empty();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
